// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller built around a 1-bit full-adder slice made from
// the gate-library half_adder and or_gate cells. Operands are shifted LSB first
// through the slice over WIDTH cycles; the result is published in one step.

// Gate-library half adder. Port quirk: "out" is the AND (carry), "c" is the XOR (sum).
module half_adder (
  input  logic a,
  input  logic b,
  output logic out,
  output logic c
);
  and g_and (out, a, b);
  xor g_xor (c, a, b);
endmodule

// Gate-library 2-input OR.
module or_gate (
  input  logic a,
  input  logic b,
  output logic out
);
  or g_or (out, a, b);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Full-adder slice: two half adders plus an OR of their carries.
  logic ha0_and, ha0_xor, ha1_and;
  logic slice_s, slice_c;

  half_adder u_ha0 (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .out (ha0_and),
    .c   (ha0_xor)
  );

  half_adder u_ha1 (
    .a   (ha0_xor),
    .b   (carry_q),
    .out (ha1_and),
    .c   (slice_s)
  );

  or_gate u_or (
    .a   (ha0_and),
    .b   (ha1_and),
    .out (slice_c)
  );

  // Next-state: load on accepted start, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d            = sa_q >> 1;
        sb_d            = sb_q >> 1;
        sr_d            = sr_q >> 1;
        sr_d[WIDTH-1]   = slice_s;
        carry_d         = slice_c;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == LastBit) begin
          // sr_d already contains the bit produced this cycle.
          sum_d   = sr_d;
          cout_d  = slice_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous clear; a reset mid-run discards the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized scoreboard bench for serial_adder_ctrl (WIDTH=8 main instance,
// plus WIDTH=4 and WIDTH=1 instances swept exhaustively).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [32:0] res;
    time         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_aux = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- WIDTH=8 instance ----------------
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(6)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  exp_t        q8[$];
  int          w8 = 0;   // cycles until the model is idle again
  logic [32:0] last8 = '0;

  // Reference model: accept start only when idle, push a+b+cin with the acceptance time.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w8 = 0;
      q8.delete();
    end else if (w8 == 0) begin
      if (start) begin
        q8.push_back('{res: 33'(a) + 33'(b) + 33'(cin), t: $time});
        w8 = W + 1;
      end
    end else begin
      w8--;
    end
  end

  // Monitor: handshake timing, result on done, result held otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last8 = '0;
    end else begin
      chk("busy8", 64'(busy), 64'(w8 >= 2));
      chk("done8", 64'(done), 64'(w8 == 1));
      if (done) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 64'(done), 64'(0));
        end else begin
          e = q8.pop_front();
          chk("sum8", 64'(sum), 64'(e.res[W-1:0]));
          chk("cout8", 64'(cout), 64'(e.res[W]));
          chk("latency8", 64'($time - e.t), 64'(W * 10 + 5));
          last8 = e.res;
        end
      end else begin
        chk("hold8", 64'({cout, sum}), 64'(last8[W:0]));
      end
    end
  end

  task automatic op8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(posedge clk);
    #1;
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W) @(posedge clk);
  endtask

  // ---------------- WIDTH=4 instance ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       cin4 = 1'b0, busy4, done4, cout4;
  exp_t       q4[$];

  serial_adder_ctrl #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk   (clk),
    .rst   (rst_aux),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  always @(negedge clk) begin
    exp_t e;
    if (!rst_aux) begin
      if (busy4 && done4) chk("busy_done4", 64'(1), 64'(0));
      if (done4) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 64'(done4), 64'(0));
        end else begin
          e = q4.pop_front();
          chk("res4", 64'({cout4, sum4}), 64'(e.res[4:0]));
          chk("latency4", 64'($time - e.t), 64'(4 * 10 + 5));
        end
      end
    end
  end

  // ---------------- WIDTH=1 instance ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       cin1 = 1'b0, busy1, done1, cout1;
  exp_t       q1[$];

  serial_adder_ctrl #(.WIDTH(1), .CNT_W(1)) dut1 (
    .clk   (clk),
    .rst   (rst_aux),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  always @(negedge clk) begin
    exp_t e;
    if (!rst_aux) begin
      if (busy1 && done1) chk("busy_done1", 64'(1), 64'(0));
      if (done1) begin
        if (q1.size() == 0) begin
          chk("unexpected_done1", 64'(done1), 64'(0));
        end else begin
          e = q1.pop_front();
          chk("res1", 64'({cout1, sum1}), 64'(e.res[1:0]));
          chk("latency1", 64'($time - e.t), 64'(1 * 10 + 5));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    rst_aux = 1'b0;

    fork
      begin : main_seq
        op8(8'h3C, 8'h5A, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h00, 8'h00, 1'b1);
        repeat (20) op8(8'($urandom), 8'($urandom), 1'($urandom));

        // start held high while operands churn every cycle
        @(posedge clk);
        #1;
        start = 1'b1;
        repeat (45) begin
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
          @(posedge clk);
          #1;
        end
        start = 1'b0;
        repeat (W + 3) @(posedge clk);

        // asynchronous reset in the middle of a run
        @(posedge clk);
        #1;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        op8(8'h01, 8'h01, 1'b0);
        @(negedge clk);
        chk("after_rst_sum", 64'(sum), 64'(2));

        // long idle: outputs must hold
        repeat (20) @(posedge clk);
      end
      begin : aux4_seq
        for (int x = 0; x < 512; x++) begin
          @(posedge clk);
          #1;
          a4 = 4'(x); b4 = 4'(x >> 4); cin4 = 1'(x >> 8); start4 = 1'b1;
          @(posedge clk);
          q4.push_back('{res: 33'(a4) + 33'(b4) + 33'(cin4), t: $time});
          #1;
          start4 = 1'b0;
          repeat (4) @(posedge clk);
        end
        repeat (4) @(posedge clk);
      end
      begin : aux1_seq
        for (int x = 0; x < 8; x++) begin
          @(posedge clk);
          #1;
          a1 = 1'(x); b1 = 1'(x >> 1); cin1 = 1'(x >> 2); start1 = 1'b1;
          @(posedge clk);
          q1.push_back('{res: 33'(a1) + 33'(b1) + 33'(cin1), t: $time});
          #1;
          start1 = 1'b0;
          repeat (1) @(posedge clk);
        end
        repeat (4) @(posedge clk);
      end
    join

    @(negedge clk);
    chk("pending8", 64'(q8.size()), 64'(0));
    chk("pending4", 64'(q4.size()), 64'(0));
    chk("pending1", 64'(q1.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It sequences a single 1-bit full-adder slice over WIDTH clock cycles to add two WIDTH-bit operands.
- The slice is built from the team's existing gate-level cells: two half_adder instances plus one or_gate.
- Mind the half_adder port quirk: its "out" port carries the AND (carry), and its "c" port carries the XOR (sum).
- The block adds operand shift registers, a carry flip-flop, a bit counter and a start/done handshake. It is the first sequential consumer of the gate library.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse (high while in DONE).
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out; holds its value until the next completion.

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and counter all cleared.
  - Reset mid-RUN discards the operation: no done pulse, sum/cout read 0.
- Clock: all flops update on rising clk; there are no negedge flops.
- State machine: IDLE -> RUN -> DONE -> IDLE. State encoding is free; no other reachable states.
- IDLE:
  - If start=1 at an edge: load sa<=a, sb<=b, carry<=cin, cnt<=0, working result register sr<=0; go to RUN.
  - Otherwise hold.
- RUN, at each edge:
  - Slice inputs: sa[0], sb[0], carry. Slice outputs: s = sa[0]^sb[0]^carry, c = majority of the three.
  - sa and sb shift right by 1 with 0 filled at the MSB.
  - sr shifts right with s entering at bit WIDTH-1; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: sum <= final shifted sr value (including this bit), cout <= c, state <= DONE.
- DONE: done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0 -> busy high after E0 -> sum/cout valid and done high after edge E(WIDTH) -> done low after E(WIDTH+1).
  - Minimum issue interval is WIDTH+2 cycles.
- Handshake rules:
  - start is ignored in RUN and DONE; it is not queued.
  - start held high continuously produces back-to-back operations, each accepted at the edge leaving DONE->IDLE +1 cycle.
  - a/b/cin changes after acceptance have no effect on the operation in flight.
- Outputs are registered only. sum/cout never show partial results; they change only at the RUN->DONE edge and at reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); there is no overflow flag.
- WIDTH=1: RUN lasts exactly one cycle.
- busy and done are never high simultaneously.
- The slice is combinational gate-level. In simulation its settling delay is zero, and the design does not rely on any primitive delay.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulsed 1 cycle -> busy high 8 cycles; done pulses once after the 8th RUN edge; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- start held high, operands changed every cycle -> operations start exactly every 10 cycles; each result matches the operands captured at acceptance; mid-run starts are ignored.
- Start 0x12+0x34, assert rst async (mid-cycle) after 4 RUN edges, then release -> busy/done/sum/cout drop to 0 immediately; no done pulse; the next op 0x01+0x01 returns sum=0x02.
- WIDTH=1 and WIDTH=4 builds, exhaustive a/b/cin against the behavioural model a+b+cin -> all match; done latency equals WIDTH cycles after the acceptance edge.
- After a completed op, leave start low for 20 cycles -> sum/cout stable, done low, busy low.
